// File: rtl/mem_lsu_if.sv
// Data-bus interface for the MEM-stage load/store unit.
// req/gnt handshake for the address phase; rvalid/rdata for read data.
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit.
// Turns loads/stores from the EXE->MEM payload into data-bus transactions,
// stalls the pipeline while one is outstanding, and produces the WB payload.
// Optional feature macro: MISALIGN_TRAP_EN -- misaligned half/word accesses
// are trapped (lsu_misalign pulse, no bus access) instead of being forced
// onto the aligned address.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_ls,
    input  logic              mem_load,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] mem_op_rs2,
    input  logic [4:0]        mem_rd_idx,
    input  logic              mem_rd_en,
    mem_lsu_if.master         dbus,
    output logic              lsu_stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd_idx,
    output logic              wb_rd_en,
    output logic [DATA_W-1:0] wb_data,
    output logic              lsu_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        alo_q;
    logic [4:0]        rd_idx_q;
    logic              rd_en_q;

    logic [1:0]        size_eff;
    logic [1:0]        a_eff;
    logic              start;
    logic              trap;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ld_data;

    // Decode the incoming op: effective size, aligned offset, lane data
    always_comb begin
        size_eff = (mem_size == 2'd3) ? 2'd2 : mem_size;
        case (size_eff)
            2'd0:    a_eff = mem_result[1:0];
            2'd1:    a_eff = {mem_result[1], 1'b0};
            default: a_eff = 2'b00;
        endcase
`ifdef MISALIGN_TRAP_EN
        trap  = mem_valid && mem_ls &&
                (((size_eff == 2'd1) && mem_result[0]) ||
                 ((size_eff == 2'd2) && (mem_result[1:0] != 2'b00)));
        start = mem_valid && mem_ls && !trap;
`else
        trap  = 1'b0;
        start = mem_valid && mem_ls;
`endif
        case (size_eff)
            2'd0: begin
                be_d    = 4'b0001 << a_eff;
                wdata_d = {4{mem_op_rs2[7:0]}};
            end
            2'd1: begin
                be_d    = 4'b0011 << a_eff;
                wdata_d = {2{mem_op_rs2[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = mem_op_rs2;
            end
        endcase
    end

    // Extract and extend load data from the returned word
    always_comb begin
        byte_v = dbus.rdata[{alo_q, 3'b000} +: 8];
        half_v = dbus.rdata[{alo_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    ld_data = {{24{!uns_q && byte_v[7]}}, byte_v};
            2'd1:    ld_data = {{16{!uns_q && half_v[15]}}, half_v};
            default: ld_data = dbus.rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and stall/request generation
    always_comb begin
        state_d   = state_q;
        lsu_stall = 1'b0;
        dbus.req  = 1'b0;
        case (state_q)
            IDLE: begin
                lsu_stall = start;
                if (start) state_d = REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                dbus.req  = 1'b1;
                if (dbus.gnt) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dbus.rvalid) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the access in IDLE so bus fields stay stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            alo_q    <= '0;
            rd_idx_q <= '0;
            rd_en_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            addr_q   <= {mem_result[ADDR_W-1:2], 2'b00};
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            we_q     <= !mem_load;
            size_q   <= size_eff;
            uns_q    <= mem_unsigned;
            alo_q    <= a_eff;
            rd_idx_q <= mem_rd_idx;
            rd_en_q  <= mem_rd_en;
        end
    end

    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.be    = be_q;
    assign dbus.wdata = wdata_q;

    // WB payload: one-cycle valid pulse, fields hold between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd_idx    <= '0;
            wb_rd_en     <= 1'b0;
            wb_data      <= '0;
            lsu_misalign <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            lsu_misalign <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid && !mem_ls) begin
                        wb_valid  <= 1'b1;
                        wb_data   <= mem_result;
                        wb_rd_idx <= mem_rd_idx;
                        wb_rd_en  <= mem_rd_en;
                    end else if (trap) begin
                        wb_valid     <= 1'b1;
                        lsu_misalign <= 1'b1;
                        wb_rd_idx    <= mem_rd_idx;
                        wb_rd_en     <= 1'b0;
                    end
                end
                REQ: begin
                    if (dbus.gnt && we_q) begin
                        wb_valid  <= 1'b1;
                        wb_rd_idx <= rd_idx_q;
                        wb_rd_en  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dbus.rvalid) begin
                        wb_valid  <= 1'b1;
                        wb_data   <= ld_data;
                        wb_rd_idx <= rd_idx_q;
                        wb_rd_en  <= rd_en_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
